// File: rtl/tpu_bus_pkg.sv
// Shared constants and types for the TPU bus responder: register offsets, error bits and control FSM states.
package tpu_bus_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned ADDR_W = 64;
  localparam int unsigned IDX_W  = 61;

  localparam logic [1:0] REG_ENABLE = 2'd0;
  localparam logic [1:0] REG_FINISH = 2'd1;
  localparam logic [1:0] REG_CYC    = 2'd2;
  localparam logic [1:0] REG_ERR    = 2'd3;

  localparam logic [DATA_W-1:0] DEADBEEF = 64'hDEAD_BEEF_DEAD_BEEF;

  localparam int unsigned ERR_UNMAPPED = 0;
  localparam int unsigned ERR_BUSY     = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/tpu_bus_ctrl_fsm.sv
// Core control FSM: start/done handshake, sticky FINISH and ERR flags, RUN cycle counter.
// The counter exists only when TPU_BUS_PERF_CNT_EN is defined; otherwise CYC reads as zero.
module tpu_bus_ctrl_fsm
  import tpu_bus_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              enable_wr,
  input  logic              finish_clr,
  input  logic [1:0]        err_clr,
  input  logic              unmapped,
  input  logic              core_done,
  output logic              core_start,
  output ctrl_state_t       state,
  output logic              finish,
  output logic [1:0]        err,
  output logic [DATA_W-1:0] cyc
);

  logic [1:0] err_set;

  // A new error event wins over a same-cycle W1C of that bit.
  always_comb begin
    err_set               = '0;
    err_set[ERR_UNMAPPED] = unmapped;
    err_set[ERR_BUSY]     = enable_wr && (state == RUN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      core_start <= 1'b0;
      finish     <= 1'b0;
      err        <= '0;
    end else begin
      core_start <= 1'b0;
      err        <= (err & ~err_clr) | err_set;
      if (finish_clr) finish <= 1'b0;
      case (state)
        IDLE: begin
          if (enable_wr) begin
            state      <= RUN;
            core_start <= 1'b1;
            finish     <= 1'b0;
          end
        end
        RUN: begin
          if (core_done) begin
            state  <= DONE;
            finish <= 1'b1;
          end
        end
        DONE: begin
          if (enable_wr) begin
            state      <= RUN;
            core_start <= 1'b1;
            finish     <= 1'b0;
          end else if (finish_clr) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TPU_BUS_PERF_CNT_EN
  // Saturating count of cycles spent in RUN, restarted by each accepted start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc <= '0;
    end else if (enable_wr && (state != RUN)) begin
      cyc <= '0;
    end else if ((state == RUN) && (cyc != '1)) begin
      cyc <= cyc + DATA_W'(1);
    end
  end
`else
  assign cyc = '0;
`endif

endmodule

// File: rtl/tpu_bus_responder.sv
// Bus target: decodes byte addresses into the UB window and the status/control registers,
// with a uniform 2-cycle read pipeline. Optional CYC counter via TPU_BUS_PERF_CNT_EN.
module tpu_bus_responder
  import tpu_bus_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR = 64'h4000_0000,
  parameter int unsigned MEM_WORDS = 4096,
  parameter logic [15:0] REG_BASE  = 16'h2E00,
  parameter int unsigned MEM_AW    = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              axi_req,
  input  logic              axi_we,
  input  logic [ADDR_W-1:0] axi_addr,
  input  logic [DATA_W-1:0] axi_wdata,
  output logic [DATA_W-1:0] axi_rdata,
  output logic              axi_rvalid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              core_start,
  input  logic              core_done
);

  logic [IDX_W-1:0]  idx;
  logic              below, in_mem, in_reg, unmapped;
  logic [1:0]        reg_off;
  logic              reg_wr;
  logic [DATA_W-1:0] reg_val;

  ctrl_state_t       state;
  logic              finish;
  logic [1:0]        err;
  logic [DATA_W-1:0] cyc;

  logic              s1_vld, s1_mem, s2_vld, s2_mem;
  logic [DATA_W-1:0] s1_data, s2_data;

  // Address decode; an address below the base wraps in the subtraction, so it is flagged separately.
  assign below    = axi_addr < BASE_ADDR;
  assign idx      = IDX_W'((axi_addr - BASE_ADDR) >> 3);
  assign in_mem   = !below && (idx < IDX_W'(MEM_WORDS));
  assign in_reg   = !below && (idx >= IDX_W'(REG_BASE)) && (idx <= IDX_W'(REG_BASE) + IDX_W'(3));
  assign unmapped = !in_mem && !in_reg;
  assign reg_off  = 2'(idx - IDX_W'(REG_BASE));
  assign reg_wr   = axi_req && axi_we && in_reg;

  always_comb begin
    reg_val = '0;
    case (reg_off)
      REG_ENABLE: reg_val = DATA_W'(state == RUN);
      REG_FINISH: reg_val = DATA_W'(finish);
      REG_CYC:    reg_val = cyc;
      REG_ERR:    reg_val = DATA_W'(err);
      default:    reg_val = '0;
    endcase
  end

  tpu_bus_ctrl_fsm u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .enable_wr  (reg_wr && (reg_off == REG_ENABLE) && axi_wdata[0]),
    .finish_clr (reg_wr && (reg_off == REG_FINISH) && axi_wdata[0]),
    .err_clr    ((reg_wr && (reg_off == REG_ERR)) ? axi_wdata[1:0] : 2'b00),
    .unmapped   (axi_req && unmapped),
    .core_done  (core_done),
    .core_start (core_start),
    .state      (state),
    .finish     (finish),
    .err        (err),
    .cyc        (cyc)
  );

  // UB forwarding, registered at the request edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_req <= axi_req && in_mem;
      mem_we  <= axi_req && axi_we && in_mem;
      if (axi_req && in_mem) begin
        mem_addr  <= MEM_AW'(idx);
        mem_wdata <= axi_wdata;
      end
    end
  end

  // Local read data is captured at the request edge and delayed to match the RAM latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_vld     <= 1'b0;
      s1_mem     <= 1'b0;
      s1_data    <= '0;
      s2_vld     <= 1'b0;
      s2_mem     <= 1'b0;
      s2_data    <= '0;
      axi_rvalid <= 1'b0;
      axi_rdata  <= '0;
    end else begin
      s1_vld     <= axi_req && !axi_we;
      s1_mem     <= in_mem;
      s1_data    <= unmapped ? DEADBEEF : reg_val;
      s2_vld     <= s1_vld;
      s2_mem     <= s1_mem;
      s2_data    <= s1_data;
      axi_rvalid <= s2_vld;
      if (s2_vld) axi_rdata <= s2_mem ? mem_rdata : s2_data;
    end
  end

endmodule

// File: tb/tb_tpu_bus_responder.sv
// Scoreboard bench for tpu_bus_responder: reads push expected data/arrival cycle, a negedge monitor pops and compares.
module tb_tpu_bus_responder;

  localparam logic [63:0] A_ENABLE = 64'h4001_7000;
  localparam logic [63:0] A_FINISH = 64'h4001_7008;
  localparam logic [63:0] A_CYC    = 64'h4001_7010;
  localparam logic [63:0] A_ERR    = 64'h4001_7018;
  localparam logic [63:0] BEEF     = 64'hDEAD_BEEF_DEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        axi_req, axi_we;
  logic [63:0] axi_addr, axi_wdata, axi_rdata;
  logic        axi_rvalid;
  logic        mem_req, mem_we;
  logic [11:0] mem_addr;
  logic [63:0] mem_wdata, mem_rdata;
  logic        core_start, core_done;

  logic [63:0] ram [0:4095];

  typedef struct {
    logic [63:0] data;
    int          due;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   checks = 0, failures = 0;
  int   ecnt = 0, start_cnt = 0, mreq_cnt = 0, rv_cnt = 0;
  int   n, snap;
  logic [63:0] exp_cyc;

  tpu_bus_responder dut (
    .clk        (clk),
    .rst        (rst),
    .axi_req    (axi_req),
    .axi_we     (axi_we),
    .axi_addr   (axi_addr),
    .axi_wdata  (axi_wdata),
    .axi_rdata  (axi_rdata),
    .axi_rvalid (axi_rvalid),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .core_start (core_start),
    .core_done  (core_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ecnt <= ecnt + 1;

  // 1-cycle synchronous RAM model
  always @(posedge clk) begin
    if (mem_req) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  // Monitor: event counters and scoreboard pop on every rvalid.
  always @(negedge clk) begin
    if (core_start) start_cnt++;
    if (mem_req) mreq_cnt++;
    if (axi_rvalid) rv_cnt++;
    if (rst && axi_rvalid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rvalid_unexpected rdata=%h at cycle %0d", axi_rdata, ecnt);
      end else begin
        e = exp_q.pop_front();
        checks += 2;
        if (axi_rdata !== e.data) begin
          failures++;
          $display("FAIL rdata act=%h exp=%h", axi_rdata, e.data);
        end
        if (ecnt != e.due) begin
          failures++;
          $display("FAIL rvalid_latency act_cycle=%0d exp_cycle=%0d", ecnt, e.due);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Called at a negedge; the following posedge is the request edge.
  task automatic bus_op(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                        input bit push, input logic [63:0] exp);
    exp_t t;
    axi_req   = 1'b1;
    axi_we    = we;
    axi_addr  = addr;
    axi_wdata = wdata;
    if (!we && push) begin
      t.data = exp;
      t.due  = ecnt + 3;
      exp_q.push_back(t);
    end
    @(negedge clk);
    axi_req = 1'b0;
    axi_we  = 1'b0;
  endtask

  task automatic wr(input logic [63:0] addr, input logic [63:0] wdata);
    bus_op(1'b1, addr, wdata, 1'b0, 64'd0);
  endtask

  task automatic rd(input logic [63:0] addr, input logic [63:0] exp);
    bus_op(1'b0, addr, 64'd0, 1'b1, exp);
  endtask

  task automatic idle(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rdata"}, axi_rdata, 64'd0);
    check({tag, "_ctl"}, 64'({axi_rvalid, mem_req, mem_we, mem_addr, core_start}), 64'd0);
    check({tag, "_wdata"}, mem_wdata, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 64'd0;
    mem_rdata = 64'd0;
    rst = 1'b0; axi_req = 1'b0; axi_we = 1'b0;
    axi_addr = 64'd0; axi_wdata = 64'd0; core_done = 1'b0;

    // 1. reset
    idle(20);
    check_outputs_zero("reset");
    rst = 1'b1;
    idle(1);
    check_outputs_zero("post_reset");
    rd(A_FINISH, 64'd0);
    idle(4);

    // 2. start, run 50 cycles, done
    n = ecnt;
    wr(A_ENABLE, 64'h1);
    rd(A_ENABLE, 64'h1);
    while (ecnt < n + 50) @(negedge clk);
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
`ifdef TPU_BUS_PERF_CNT_EN
    exp_cyc = 64'd50;
`else
    exp_cyc = 64'd0;
`endif
    rd(A_FINISH, 64'h1);
    rd(A_CYC, exp_cyc);
    rd(A_ENABLE, 64'h0);
    idle(1);
    check("start_pulses_1", 64'(start_cnt), 64'd1);
    wr(A_FINISH, 64'h1);
    rd(A_FINISH, 64'h0);
    idle(4);

    // 3. UB window
    wr(64'h4000_0008, 64'hA5A5);
    check("mem_req_wr", 64'(mem_req), 64'd1);
    check("mem_we_wr", 64'(mem_we), 64'd1);
    check("mem_addr_wr", 64'(mem_addr), 64'd1);
    check("mem_wdata_wr", mem_wdata, 64'hA5A5);
    idle(1);
    rd(64'h4000_0008, 64'hA5A5);
    wr(64'h4000_0010, 64'h1111_2222_3333_4444);
    wr(64'h4000_0018, 64'h5555_6666_7777_8888);
    rd(64'h4000_0010, 64'h1111_2222_3333_4444);
    rd(64'h4000_0018, 64'h5555_6666_7777_8888);
    rd(64'h4000_0008, 64'hA5A5);
    wr(64'h4000_7FF8, 64'hFEED_FACE_0000_0FFF);
    check("mem_addr_last", 64'(mem_addr), 64'hFFF);
    rd(64'h4000_7FF8, 64'hFEED_FACE_0000_0FFF);
    idle(4);
    rd(A_ERR, 64'h0);
    idle(4);

    // 4. unmapped accesses
    snap = mreq_cnt;
    rd(64'h4000_9000, BEEF);
    rd(64'h4000_8000, BEEF);
    idle(4);
    check("no_mem_req_unmapped", 64'(mreq_cnt), 64'(snap));
    rd(A_ERR, 64'h1);
    wr(A_ERR, 64'h1);
    rd(A_ERR, 64'h0);
    rd(64'h3FFF_FFF8, BEEF);
    rd(A_ERR, 64'h1);
    wr(A_ERR, 64'h1);
    wr(64'h4001_7020, 64'h1);
    rd(A_ERR, 64'h1);
    wr(A_ERR, 64'h1);
    idle(4);

    // 5. enable while busy, coincident done
    snap = start_cnt;
    wr(A_ENABLE, 64'h1);
    wr(A_ENABLE, 64'h1);
    rd(A_ENABLE, 64'h1);
    rd(A_ERR, 64'h2);
    core_done = 1'b1;
    wr(A_ENABLE, 64'h1);
    core_done = 1'b0;
    idle(2);
    check("start_pulses_busy", 64'(start_cnt), 64'(snap + 1));
    rd(A_ENABLE, 64'h0);
    rd(A_FINISH, 64'h1);
    rd(A_ERR, 64'h2);
    wr(A_ERR, 64'h3);
    rd(A_ERR, 64'h0);
    wr(A_FINISH, 64'h1);
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    rd(A_FINISH, 64'h0);
    rd(A_ENABLE, 64'h0);
    idle(4);

    // 6. reset during an in-flight UB read while running
    wr(A_ENABLE, 64'h1);
    idle(2);
    snap = rv_cnt;
    bus_op(1'b0, 64'h4000_0008, 64'd0, 1'b0, 64'd0);
    rst = 1'b0;
    idle(2);
    check_outputs_zero("mid_reset");
    rst = 1'b1;
    idle(4);
    check("no_rvalid_after_reset", 64'(rv_cnt), 64'(snap));
    rd(A_ENABLE, 64'h0);
    rd(A_FINISH, 64'h0);

    idle(6);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
